// File: rtl/bpu_btb_bimodal_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : bpu_btb_bimodal_if                                           |
// | Desc   : Fetch-lookup / resolve-update bundle for the bimodal BTB.    |
// |          master = fetch/execute side, slave = the BTB itself.         |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
interface bpu_btb_bimodal_if #(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
);
  logic                 fetch_valid;
  logic [PC_WIDTH-1:0]  fetch_pc;
  logic                 pred_taken;
  logic [PC_WIDTH-1:0]  pred_target;
  logic                 upd_valid;
  logic [PC_WIDTH-1:0]  upd_pc;
  logic                 upd_taken;
  logic [PC_WIDTH-1:0]  upd_target;
  logic                 upd_pred_taken;
  logic [CNT_WIDTH-1:0] mispredict_cnt;

  modport master (
    output fetch_valid, fetch_pc,
    output upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken,
    input  pred_taken, pred_target, mispredict_cnt
  );

  modport slave (
    input  fetch_valid, fetch_pc,
    input  upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken,
    output pred_taken, pred_target, mispredict_cnt
  );
endinterface
`default_nettype wire

// File: rtl/bpu_btb_bimodal.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : bpu_btb_bimodal                                              |
// | Desc   : Direct-mapped BTB with 2-bit bimodal counters. 0-cycle       |
// |          lookup on fetch_pc, registered training from execute, and a  |
// |          saturating direction-mispredict counter.                     |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
module bpu_btb_bimodal #(
  parameter int PC_WIDTH  = 32,
  parameter int ENTRIES   = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  bpu_btb_bimodal_if.slave       bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_WIDTH - IDX_W - 2;

  // Table storage: valid and counters are reset, tag/target are not.
  logic [ENTRIES-1:0]   valid_q;
  logic [TAG_W-1:0]     tag_q    [ENTRIES];
  logic [PC_WIDTH-1:0]  target_q [ENTRIES];
  logic [1:0]           ctr_q    [ENTRIES];
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic             f_hit, u_hit;
  logic [1:0]       ctr_d;
  logic             ctr_we;
  logic             alloc;

  // Byte-offset bits are not part of index or tag.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.fetch_pc[1:0], bus.upd_pc[1:0]};

  assign f_idx = bus.fetch_pc[IDX_W+1:2];
  assign f_tag = bus.fetch_pc[PC_WIDTH-1:IDX_W+2];
  assign u_idx = bus.upd_pc[IDX_W+1:2];
  assign u_tag = bus.upd_pc[PC_WIDTH-1:IDX_W+2];

  // Lookup sees pre-update state only; there is deliberately no bypass.
  always_comb begin
    f_hit           = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    bus.pred_taken  = bus.fetch_valid & f_hit & ctr_q[f_idx][1];
    bus.pred_target = f_hit ? target_q[f_idx] : '0;
  end

  // Training decision: saturating counter step on hit, allocation on taken miss.
  always_comb begin
    u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    ctr_d  = ctr_q[u_idx];
    ctr_we = 1'b0;
    alloc  = 1'b0;
    if (bus.upd_valid) begin
      if (u_hit) begin
        ctr_we = 1'b1;
        if (bus.upd_taken) begin
          if (ctr_q[u_idx] != 2'b11) ctr_d = ctr_q[u_idx] + 2'd1;
        end else begin
          if (ctr_q[u_idx] != 2'b00) ctr_d = ctr_q[u_idx] - 2'd1;
        end
      end else if (bus.upd_taken) begin
        ctr_we = 1'b1;
        alloc  = 1'b1;
        ctr_d  = 2'b10;
      end
    end
    cnt_d = cnt_q;
    if (bus.upd_valid && (bus.upd_taken != bus.upd_pred_taken) && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  assign bus.mispredict_cnt = cnt_q;

  // Valid bits, counters and mispredict count; reset drops any same-cycle update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (ctr_we) ctr_q[u_idx]   <= ctr_d;
      if (alloc)  valid_q[u_idx] <= 1'b1;
    end
  end

  // Tag/target written on any taken update: rewrite on hit, fill on miss.
  // A write during reset is harmless because the entry stays invalid.
  always_ff @(posedge clk) begin
    if (bus.upd_valid && bus.upd_taken) begin
      tag_q[u_idx]    <= u_tag;
      target_q[u_idx] <= bus.upd_target;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_bpu_btb_bimodal.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : tb_bpu_btb_bimodal                                           |
// | Desc   : Directed self-checking bench for bpu_btb_bimodal             |
// |          (ENTRIES=16, CNT_WIDTH=4).                                   |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
module tb_bpu_btb_bimodal;
  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_cnt = 0;

  bpu_btb_bimodal_if #(.PC_WIDTH(32), .CNT_WIDTH(4)) bus ();

  bpu_btb_bimodal #(.PC_WIDTH(32), .ENTRIES(16), .CNT_WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected saturating mispredict count (4-bit).
  task automatic note_mis(input logic taken, input logic pred);
    if (taken != pred && exp_cnt < 15) exp_cnt++;
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken,
                     input logic [31:0] tgt, input logic pred);
    @(negedge clk);
    bus.upd_pc = pc; bus.upd_taken = taken; bus.upd_target = tgt;
    bus.upd_pred_taken = pred; bus.upd_valid = 1'b1;
    note_mis(taken, pred);
    @(posedge clk);
    #1 bus.upd_valid = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    bus.fetch_pc = pc; bus.fetch_valid = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.fetch_valid = 1'b1; bus.fetch_pc = 32'h100;
    bus.upd_valid = 1'b0; bus.upd_pc = '0; bus.upd_taken = 1'b0;
    bus.upd_target = '0; bus.upd_pred_taken = 1'b0;
    #1;
    chk("rst_pred_taken", {31'b0, bus.pred_taken}, 32'd0);
    chk("rst_pred_target", bus.pred_target, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // 1: empty table
    look(32'h100);
    chk("t1_taken", {31'b0, bus.pred_taken}, 32'd0);
    chk("t1_cnt", {28'b0, bus.mispredict_cnt}, 32'd0);

    // 2: allocate 0x100 -> 0x200, weakly taken
    upd(32'h100, 1'b1, 32'h200, 1'b0);
    look(32'h100);
    chk("t2_taken", {31'b0, bus.pred_taken}, 32'd1);
    chk("t2_target", bus.pred_target, 32'h200);
    chk("t2_cnt", {28'b0, bus.mispredict_cnt}, 32'd1);

    // 3: counter walk 10->01->10->11->11->10->01->00->00->01->10
    upd(32'h100, 1'b0, 32'h0, 1'b1);   look(32'h100);
    chk("t3a_taken", {31'b0, bus.pred_taken}, 32'd0);
    chk("t3a_target_kept", bus.pred_target, 32'h200);
    upd(32'h100, 1'b1, 32'h300, 1'b0); look(32'h100);
    chk("t3b_taken", {31'b0, bus.pred_taken}, 32'd1);
    chk("t3b_target_new", bus.pred_target, 32'h300);
    upd(32'h100, 1'b1, 32'h300, 1'b1); look(32'h100);
    chk("t3c_taken", {31'b0, bus.pred_taken}, 32'd1);
    upd(32'h100, 1'b1, 32'h300, 1'b1); look(32'h100);
    chk("t3d_sat11", {31'b0, bus.pred_taken}, 32'd1);
    upd(32'h100, 1'b0, 32'h0, 1'b1);   look(32'h100);
    chk("t3e_taken", {31'b0, bus.pred_taken}, 32'd1);
    upd(32'h100, 1'b0, 32'h0, 1'b1);   look(32'h100);
    chk("t3f_taken", {31'b0, bus.pred_taken}, 32'd0);
    upd(32'h100, 1'b0, 32'h0, 1'b0);   look(32'h100);
    chk("t3g_taken", {31'b0, bus.pred_taken}, 32'd0);
    upd(32'h100, 1'b0, 32'h0, 1'b0);   look(32'h100);
    chk("t3h_sat00", {31'b0, bus.pred_taken}, 32'd0);
    upd(32'h100, 1'b1, 32'h300, 1'b0); look(32'h100);
    chk("t3i_taken", {31'b0, bus.pred_taken}, 32'd0);
    upd(32'h100, 1'b1, 32'h300, 1'b0); look(32'h100);
    chk("t3j_taken", {31'b0, bus.pred_taken}, 32'd1);
    chk("t3_cnt", {28'b0, bus.mispredict_cnt}, 32'd7);
    chk("t3_cnt_model", {28'b0, bus.mispredict_cnt}, exp_cnt);

    // 4: alias 0x140 shares index 0 with 0x100
    look(32'h140);
    chk("t4_alias_miss", {31'b0, bus.pred_taken}, 32'd0);
    chk("t4_alias_tgt0", bus.pred_target, 32'd0);
    upd(32'h140, 1'b1, 32'h500, 1'b1);
    look(32'h140);
    chk("t4_alias_hit", {31'b0, bus.pred_taken}, 32'd1);
    chk("t4_alias_target", bus.pred_target, 32'h500);
    look(32'h100);
    chk("t4_orig_evicted", {31'b0, bus.pred_taken}, 32'd0);
    upd(32'h180, 1'b0, 32'h777, 1'b0);   // not-taken miss: no change
    look(32'h140);
    chk("t4_nt_miss_keep", bus.pred_target, 32'h500);
    bus.fetch_valid = 1'b0; #1;
    chk("t4_fetch_invalid", {31'b0, bus.pred_taken}, 32'd0);

    // 5: same-cycle allocate and lookup of 0x208
    @(negedge clk);
    bus.fetch_pc = 32'h208; bus.fetch_valid = 1'b1;
    bus.upd_pc = 32'h208; bus.upd_taken = 1'b1; bus.upd_target = 32'h900;
    bus.upd_pred_taken = 1'b0; bus.upd_valid = 1'b1;
    note_mis(1'b1, 1'b0);
    #1 chk("t5_same_cycle", {31'b0, bus.pred_taken}, 32'd0);
    @(posedge clk);
    #1 bus.upd_valid = 1'b0;
    chk("t5_next_cycle", {31'b0, bus.pred_taken}, 32'd1);
    chk("t5_target", bus.pred_target, 32'h900);
    chk("t5_cnt", {28'b0, bus.mispredict_cnt}, 32'd8);

    // 6: saturate the 4-bit counter, then async reset mid-stream
    for (int i = 0; i < 20; i++)
      upd(32'h400 + 32'(i * 64), 1'b1, 32'h1000, 1'b0);
    #1 chk("t6_cnt_sat", {28'b0, bus.mispredict_cnt}, 32'd15);
    chk("t6_cnt_model", {28'b0, bus.mispredict_cnt}, exp_cnt);
    @(negedge clk);
    bus.upd_pc = 32'h208; bus.upd_taken = 1'b1; bus.upd_target = 32'hA00;
    bus.upd_pred_taken = 1'b0; bus.upd_valid = 1'b1;
    #2 rst_n = 1'b0;
    exp_cnt = 0;
    #1 chk("t6_rst_cnt", {28'b0, bus.mispredict_cnt}, 32'd0);
    look(32'h140);
    chk("t6_rst_0x140", {31'b0, bus.pred_taken}, 32'd0);
    look(32'h208);
    chk("t6_rst_0x208", {31'b0, bus.pred_taken}, 32'd0);
    chk("t6_rst_target", bus.pred_target, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    bus.upd_valid = 1'b0;
    rst_n = 1'b1;
    look(32'h208);
    chk("t6_post_rst_miss", {31'b0, bus.pred_taken}, 32'd0);
    chk("t6_post_rst_cnt", {28'b0, bus.mispredict_cnt}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
